// File: rtl/tone_pkg.sv
// Shared constants for the tone synthesiser: semitone frequency table, rest threshold,
// channel state encoding and the elaboration-time half-period calculation.
package tone_pkg;

  localparam int unsigned REST = 12;

  typedef enum logic {StIdle, StRun} ch_state_e;

  // Frequencies of C3..B3 scaled by 100; notes at or above REST map to C3.
  function automatic int unsigned f100(input logic [3:0] note);
    case (note)
      4'd0:    f100 = 13081;
      4'd1:    f100 = 13859;
      4'd2:    f100 = 14683;
      4'd3:    f100 = 15556;
      4'd4:    f100 = 16481;
      4'd5:    f100 = 17461;
      4'd6:    f100 = 18500;
      4'd7:    f100 = 19600;
      4'd8:    f100 = 20765;
      4'd9:    f100 = 22000;
      4'd10:   f100 = 23308;
      4'd11:   f100 = 24694;
      default: f100 = 13081;
    endcase
  endfunction

  // round(clk_hz*100 / (2*f100)); only ever evaluated for localparams.
  function automatic int unsigned hp_calc(input int unsigned clk_hz, input logic [3:0] note);
    longint unsigned num;
    longint unsigned den;
    num = 64'(clk_hz) * 64'd100;
    den = 64'd2 * 64'(f100(note));
    hp_calc = 32'((num + den / 64'd2) / den);
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave tone channel: half-period down-counter, wave flip-flop and a one-deep
// pending register so a new pitch takes effect only at a half-period boundary.
module tone_channel
  import tone_pkg::*;
#(
  parameter int unsigned CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          play,
  input  logic          stop,
  input  logic [CW-1:0] half,
  output logic          wave,
  output logic          active,
  output logic          pending
);

  ch_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cur_q, cur_d;
  logic [CW-1:0] pend_half_q, pend_half_d;
  logic          pend_q, pend_d;
  logic          wave_q, wave_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    pend_half_d = pend_half_q;
    pend_d      = pend_q;
    wave_d      = wave_q;
    if (stop) begin
      state_d = StIdle;
      wave_d  = 1'b0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (play) begin
            state_d = StRun;
            wave_d  = 1'b1;
            cnt_d   = half - CW'(1);
            cur_d   = half;
          end
        end
        StRun: begin
          if (cnt_q == '0) begin
            wave_d = ~wave_q;
            if (pend_q) begin
              cnt_d  = pend_half_q - CW'(1);
              cur_d  = pend_half_q;
              pend_d = 1'b0;
            end else if (play) begin
              // Command landing exactly on a boundary takes effect immediately.
              cnt_d = half - CW'(1);
              cur_d = half;
            end else begin
              cnt_d = cur_q - CW'(1);
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
            if (play) begin
              pend_d      = 1'b1;
              pend_half_d = half;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cur_q       <= '0;
      pend_half_q <= '0;
      pend_q      <= 1'b0;
      wave_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      pend_half_q <= pend_half_d;
      pend_q      <= pend_d;
      wave_q      <= wave_d;
    end
  end

  assign wave    = wave_q;
  assign active  = (state_q == StRun);
  assign pending = pend_q;

endmodule

// File: rtl/tone_synth.sv
// Multi-channel square-wave tone synthesiser: command decode and back-pressure, a shared
// half-period lookup, NUM_CH channel instances and a registered count of high waves.
module tone_synth
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned OCT_BITS = 3,
  localparam int unsigned CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned MW      = $clog2(NUM_CH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CHW-1:0]      cmd_ch,
  input  logic [3:0]          cmd_note,
  input  logic [OCT_BITS-1:0] cmd_octave,
  input  logic                cmd_gate,
  output logic [NUM_CH-1:0]   wave,
  output logic [NUM_CH-1:0]   active,
  output logic [MW-1:0]       mix
);

  localparam int unsigned HP_MAX = hp_calc(CLK_HZ, 4'd0);
  localparam int unsigned CW     = $clog2(HP_MAX + 1);

  // Rest codes fill the upper entries so the 4-bit note indexes the table directly.
  localparam logic [CW-1:0] HP_TAB [16] = '{
    CW'(hp_calc(CLK_HZ, 4'd0)), CW'(hp_calc(CLK_HZ, 4'd1)), CW'(hp_calc(CLK_HZ, 4'd2)),
    CW'(hp_calc(CLK_HZ, 4'd3)), CW'(hp_calc(CLK_HZ, 4'd4)), CW'(hp_calc(CLK_HZ, 4'd5)),
    CW'(hp_calc(CLK_HZ, 4'd6)), CW'(hp_calc(CLK_HZ, 4'd7)), CW'(hp_calc(CLK_HZ, 4'd8)),
    CW'(hp_calc(CLK_HZ, 4'd9)), CW'(hp_calc(CLK_HZ, 4'd10)), CW'(hp_calc(CLK_HZ, 4'd11)),
    CW'(HP_MAX), CW'(HP_MAX), CW'(HP_MAX), CW'(HP_MAX)
  };

  logic [NUM_CH-1:0] sel, pending, play, stop;
  logic [CW-1:0]     half_sh, half;
  logic              is_play, accept;
  logic [MW-1:0]     pop, mix_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i] = (32'(cmd_ch) == 32'(i));
    end
  end

  assign is_play   = cmd_gate && (cmd_note < 4'(REST));
  assign cmd_ready = !(is_play && |(pending & sel));
  assign accept    = cmd_valid && cmd_ready;
  assign play      = (accept && is_play) ? sel : '0;
  assign stop      = (accept && !is_play) ? sel : '0;

  assign half_sh = HP_TAB[cmd_note] >> cmd_octave;
  assign half    = (half_sh == '0) ? CW'(1) : half_sh;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tone_channel #(
      .CW(CW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .play   (play[g]),
      .stop   (stop[g]),
      .half   (half),
      .wave   (wave[g]),
      .active (active[g]),
      .pending(pending[g])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + MW'(wave[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mix_q <= '0;
    end else begin
      mix_q <= pop;
    end
  end

  assign mix = mix_q;

endmodule

// File: doc/tone_synth.md
TONE_SYNTH -- requirements
Module: tone_synth

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter NUM_CH, default 4, number of independent tone channels (1..16).
REQ-003 Parameter OCT_BITS, default 3, octave field width; octave 0 = C3 base, octave k = base × 2^k.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-008 cmd_ch  input  clog2(NUM_CH) (min 1)  target channel.
REQ-009 cmd_note  input  4  semitone 0..11 = C..B; 12..15 = rest.
REQ-010 cmd_octave  input  OCT_BITS  octave above C3.
REQ-011 cmd_gate  input  1  1 = play note, 0 = stop channel.
REQ-012 wave  output  NUM_CH  per-channel square wave.
REQ-013 active  output  NUM_CH  per-channel running flag.
REQ-014 mix  output  clog2(NUM_CH+1)  count of channels with wave high, registered.

Function
REQ-015 Base half-period table HP[n] for n = 0..11 SHALL be elaboration-time constants equal to round(CLK_HZ×100 / (2×F100[n])), where F100 is the x100 frequency table C3..B3: 13081, 13859, 14683, 15556, 16481, 17461, 18500, 19600, 20765, 22000, 23308, 24694.
REQ-016 Effective half-period SHALL be HP[note] >> octave, clamped to a minimum of 1.
REQ-017 Counter width SHALL be clog2(HP[0]+1); no runtime division.
REQ-018 Per-channel states: IDLE (wave=0, active=0, counter held) and RUN (active=1).
REQ-019 In RUN, the counter decrements each cycle; at 0 it reloads half-period−1 and wave toggles.
REQ-020 Play command (gate=1, note<12) to an IDLE channel: next cycle RUN, wave=1, counter=half−1.
REQ-021 Play command to a RUN channel SHALL set a per-channel pending register; the pending half-period is loaded at the next reload (counter=0), and phase stays continuous.
REQ-022 If a play command is accepted on the same cycle the target counter is 0 and no update is pending, the new half-period SHALL be used for that reload directly.
REQ-023 Stop command (gate=0) or rest note SHALL immediately force IDLE, wave=0, pending cleared, next cycle.
REQ-024 cmd_ready SHALL be combinational: 0 only when cmd_gate=1, cmd_note<12 and pending[cmd_ch]=1; stop and rest commands are always accepted.
REQ-025 cmd_ch ≥ NUM_CH SHALL be accepted and ignored.
REQ-026 mix SHALL equal popcount(wave) delayed by one cycle.

Reset
REQ-027 While rst=1 at an edge: all channels IDLE, wave=0, active=0, counters=0, pending=0, mix=0; cmd_ready evaluates per REQ-024 with pending=0.
REQ-028 Reset asserted mid-note SHALL abort with no residual pending update after release.

Structure
REQ-029 Package tone_pkg SHALL hold the F100 table, the REST threshold (12), and a constant function computing HP from CLK_HZ.
REQ-030 Sub-module tone_channel SHALL implement one channel (counter, pending register, wave FF) and is instantiated NUM_CH times; the top handles decode, ready, and mix.

Verification (CLK_HZ=1_000_000, NUM_CH=4, OCT_BITS=3; HP[A]=2273)
REQ-031 Reset, then play ch0 A oct0 -> wave[0] high 2273 cycles, low 2273, repeating; active[0]=1.
REQ-032 ch0 running A oct0; play A oct2 mid-phase -> current half completes at 2273, then halves of 568; cmd_ready low for ch0 until the swap.
REQ-033 Second play to ch0 while pending -> cmd_ready=0, held command accepted the cycle after the swap; a play to ch1 stays accepted meanwhile.
REQ-034 Play all 4 channels with the same note on the same cycle -> mix reaches 4 one cycle after the waves go high; stop ch2 -> mix 3 the cycle after wave[2] falls.
REQ-035 Rest note (13) to a running channel -> wave=0, active=0 next cycle, cmd_ready=1.
REQ-036 Assert rst for 1 cycle mid-half with an update pending -> all outputs 0, and no swap after release.
